// File: rtl/mips_bus_mem_ctrl.sv
// Avalon-MM slave that turns CPU bus requests into single-cycle SRAM accesses with WAIT_STATES stall cycles.
// Optional counters stat_reads/stat_writes/stat_stalls are enabled by defining MIPS_BUS_MEM_CTRL_STATS_EN.
module mips_bus_mem_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           address,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic                  proto_err
`ifdef MIPS_BUS_MEM_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_stalls
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  count;
  logic        op_wr;
  logic [31:0] hold;
  logic        req;

  // Alignment and upper address bits are the master's concern.
  logic unused_addr;
  assign unused_addr = ^{address[31:ADDR_WIDTH+2], address[1:0]};

  assign req = read | write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      op_wr     <= 1'b0;
      hold      <= 32'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (read && write) proto_err <= 1'b1;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            mem_addr  <= address[ADDR_WIDTH+1:2];
            mem_wdata <= writedata;
            mem_be    <= byteenable;
            op_wr     <= write;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              count <= WS;
            end else begin
              state  <= S_ISSUE;
              mem_we <= write && (|byteenable);
              mem_re <= !write;
            end
          end
        end
        S_WAIT: begin
          // A dropped request abandons the transfer before the SRAM is touched.
          if (!req) begin
            state <= S_IDLE;
            count <= 4'd0;
          end else if (count == 4'd1) begin
            state  <= S_ISSUE;
            count  <= 4'd0;
            mem_we <= op_wr && (|mem_be);
            mem_re <= !op_wr;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_ISSUE: state <= S_DONE;
        S_DONE: begin
          state <= S_IDLE;
          if (!op_wr) hold <= mem_rdata;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    waitrequest = 1'b1;
    case (state)
      S_IDLE:  waitrequest = req;
      S_DONE:  waitrequest = 1'b0;
      default: waitrequest = 1'b1;
    endcase
  end

  assign readdata = (state == S_DONE && !op_wr) ? mem_rdata : hold;

`ifdef MIPS_BUS_MEM_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (state == S_DONE) begin
        if (op_wr) stat_writes <= stat_writes + 32'd1;
        else       stat_reads  <= stat_reads + 32'd1;
      end
      if (waitrequest) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_bus_mem_ctrl.sv
// Directed bench: four controllers with WAIT_STATES 0, 3, 4 and 1, each backed by a small SRAM model.
module tb_mips_bus_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  read = 4'd0;
  logic [3:0]  write = 4'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  byteenable = 4'd0;
  logic [3:0]  waitreq;
  logic [3:0]  mem_we;
  logic [3:0]  mem_re;
  logic [3:0]  proto_err;
  logic [31:0] readdata [4];
  logic [15:0] mem_addr [4];
  logic [31:0] mem_wdata [4];
  logic [3:0]  mem_be [4];
`ifdef MIPS_BUS_MEM_CTRL_STATS_EN
  logic [31:0] stat_reads [4];
  logic [31:0] stat_writes [4];
  logic [31:0] stat_stalls [4];
`endif

  int n_checks = 0;
  int n_errs = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 4 : 1;
    logic [31:0] sram [256];
    logic [31:0] rdata_q;

    mips_bus_mem_ctrl #(.ADDR_WIDTH(16), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(rst), .read(read[g]), .write(write[g]),
      .address(address), .writedata(writedata), .byteenable(byteenable),
      .waitrequest(waitreq[g]), .readdata(readdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]),
      .mem_we(mem_we[g]), .mem_re(mem_re[g]), .mem_rdata(rdata_q),
      .proto_err(proto_err[g])
`ifdef MIPS_BUS_MEM_CTRL_STATS_EN
      , .stat_reads(stat_reads[g]), .stat_writes(stat_writes[g]), .stat_stalls(stat_stalls[g])
`endif
    );

    always @(posedge clk) begin
      if (mem_re[g]) rdata_q <= sram[mem_addr[g][7:0]];
      if (mem_we[g])
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) sram[mem_addr[g][7:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Holds one request until waitrequest falls; cycle 1 is the IDLE cycle the request is raised in.
  task automatic xfer(input int i, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int n_wait, output int we_cyc, output int re_cyc,
                      output int n_we, output int n_re, output logic [31:0] rdat);
    int  cyc;
    bit  done;
    @(posedge clk); #1;
    read[i] = rd; write[i] = wr; address = a; writedata = wd; byteenable = be;
    n_wait = 0; we_cyc = 0; re_cyc = 0; n_we = 0; n_re = 0; rdat = 32'hx;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_we[i]) begin n_we++; we_cyc = cyc; end
      if (mem_re[i]) begin n_re++; re_cyc = cyc; end
      if (waitreq[i]) n_wait++;
      else begin done = 1; rdat = readdata[i]; end
    end
    check("xfer_completes", 32'(done), 32'd1);
    @(posedge clk); #1;
    read[i] = 1'b0; write[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nw, wc, rc, nwe, nre, cnt;
    logic [31:0] rdv;

    #1 rst = 1'b1;
    #20 rst = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check("rst_waitreq", waitreq[i], 0);
      check("rst_readdata", readdata[i], 32'd0);
      check("rst_strobes", {mem_we[i], mem_re[i]}, 0);
      check("rst_proto_err", proto_err[i], 0);
      check("rst_mem_addr", mem_addr[i], 0);
    end

    // WAIT_STATES=1: three transfers, each stalled 3 cycles.
    xfer(3, 0, 1, 32'h8, 32'h0000_0077, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws1_wr_wait", nw, 3);
    check("ws1_wr_we_cyc", wc, 3);
    xfer(3, 1, 0, 32'h8, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws1_rd_data", rdv, 32'h77);
    xfer(3, 1, 0, 32'h8, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws1_rd2_wait", nw, 3);
`ifdef MIPS_BUS_MEM_CTRL_STATS_EN
    check("stat_reads", stat_reads[3], 2);
    check("stat_writes", stat_writes[3], 1);
    check("stat_stalls", stat_stalls[3], 9);
`endif

    // WAIT_STATES=0 write then read.
    xfer(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws0_wr_wait", nw, 2);
    check("ws0_wr_we_cnt", nwe, 1);
    check("ws0_wr_we_cyc", wc, 2);
    check("ws0_wr_no_re", nre, 0);
    xfer(0, 1, 0, 32'h10, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws0_rd_wait", nw, 2);
    check("ws0_rd_re_cnt", nre, 1);
    check("ws0_rd_re_cyc", rc, 2);
    check("ws0_rd_no_we", nwe, 0);
    check("ws0_rd_data", rdv, 32'hDEAD_BEEF);
    check("ws0_rd_hold", readdata[0], 32'hDEAD_BEEF);
    xfer(0, 1, 0, 32'h13, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws0_unaligned_rd", rdv, 32'hDEAD_BEEF);
    check("ws0_word_addr", mem_addr[0], 16'h4);

    // Byte lanes.
    xfer(0, 0, 1, 32'h30, 32'h1122_3344, 4'hF, nw, wc, rc, nwe, nre, rdv);
    xfer(0, 0, 1, 32'h30, 32'hAABB_CCDD, 4'b0010, nw, wc, rc, nwe, nre, rdv);
    xfer(0, 1, 0, 32'h30, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("be_lane1_rd", rdv, 32'h1122_CC44);
    xfer(0, 0, 1, 32'h30, 32'hFFFF_FFFF, 4'b0000, nw, wc, rc, nwe, nre, rdv);
    check("be0_no_we", nwe, 0);
    check("be0_wait", nw, 2);
    xfer(0, 1, 0, 32'h30, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("be0_unchanged", rdv, 32'h1122_CC44);

    // WAIT_STATES=3 read.
    xfer(1, 0, 1, 32'h20, 32'h1234_5678, 4'hF, nw, wc, rc, nwe, nre, rdv);
    xfer(1, 1, 0, 32'h20, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws3_rd_wait", nw, 5);
    check("ws3_re_cnt", nre, 1);
    check("ws3_re_cyc", rc, 5);
    check("ws3_rd_data", rdv, 32'h1234_5678);

    // WAIT_STATES=4 abort in the second WAIT cycle.
    xfer(2, 0, 1, 32'h60, 32'hCAFE_0001, 4'hF, nw, wc, rc, nwe, nre, rdv);
    xfer(2, 1, 0, 32'h60, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("ws4_rd_wait", nw, 6);
    check("ws4_rd_data", rdv, 32'hCAFE_0001);
    @(posedge clk); #1;
    read[2] = 1'b1; address = 32'h60;
    @(posedge clk); #1;
    @(posedge clk); #1;
    read[2] = 1'b0;
    @(negedge clk);
    check("abort_still_wait", waitreq[2], 1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check("abort_idle", waitreq[2], 0);
      if (mem_re[2]) cnt++;
    end
    check("abort_no_re", cnt, 0);
    check("abort_readdata", readdata[2], 32'hCAFE_0001);

    // read and write together.
    xfer(0, 1, 1, 32'h40, 32'h5, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("rw_we_cnt", nwe, 1);
    check("rw_no_re", nre, 0);
    check("rw_proto_err", proto_err[0], 1);
    xfer(0, 1, 0, 32'h40, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("rw_wrote", rdv, 32'h5);
    check("proto_err_sticky", proto_err[0], 1);

    // Asynchronous reset during ISSUE of a write.
    @(posedge clk); #1;
    write[0] = 1'b1; address = 32'h40; writedata = 32'h99; byteenable = 4'hF;
    @(posedge clk); #1;
    check("issue_we", mem_we[0], 1);
    rst = 1'b1; write[0] = 1'b0;
    #1;
    check("async_rst_we", mem_we[0], 0);
    check("async_rst_proto_err", proto_err[0], 0);
    check("async_rst_readdata", readdata[0], 32'd0);
    check("async_rst_mem_addr", mem_addr[0], 16'h0);
    #2 rst = 1'b0;
    xfer(0, 1, 0, 32'h40, 32'h0, 4'hF, nw, wc, rc, nwe, nre, rdv);
    check("no_partial_write", rdv, 32'h5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mips_bus_mem_ctrl.md
Name: mips_bus_mem_ctrl

Overview:
Avalon-MM-style memory slave that sits directly downstream of the pipelined CPU bus master and serves its read/write/byteenable requests. It converts each bus request into a single-cycle access on a synchronous single-port SRAM. It inserts a programmable number of wait states and generates waitrequest back to the CPU. It is the bench/SoC memory front-end for the instruction and data traffic the CPU multiplexes onto one address port.

Parameters:
ADDR_WIDTH, 16, word-address width driven to SRAM; bus address bits [ADDR_WIDTH+1:2] used, others ignored
WAIT_STATES, 0, extra stall cycles inserted before each SRAM access (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
read  input  1  CPU read request
write  input  1  CPU write request
address  input  32  CPU byte address
writedata  input  32  CPU write data
byteenable  input  4  CPU byte lanes, bit i = bits [8i+7:8i]
waitrequest  output  1  high = request not yet completed
readdata  output  32  read data, valid in completing cycle, held afterwards
mem_addr  output  ADDR_WIDTH  SRAM word address
mem_wdata  output  32  SRAM write data
mem_be  output  4  SRAM byte write enables
mem_we  output  1  SRAM write strobe
mem_re  output  1  SRAM read strobe, data on mem_rdata next cycle
mem_rdata  input  32  SRAM read data
proto_err  output  1  sticky: read and write seen together

Behaviour:
- Reset, asynchronous: state=IDLE, counter=0, mem_we=mem_re=0, mem_addr/mem_wdata/mem_be=0, readdata hold reg=0, proto_err=0. waitrequest then follows IDLE rule.
- FSM states: IDLE, WAIT, ISSUE, DONE.
- IDLE:
  - waitrequest = read|write (combinational).
  - On read|write, latch address[ADDR_WIDTH+1:2], writedata, byteenable, op (write has priority).
  - Next state is WAIT with counter=WAIT_STATES if WAIT_STATES>0, else ISSUE.
- WAIT:
  - waitrequest=1; counter decrements each cycle; go to ISSUE when counter==1.
  - If read|write drops, abort to IDLE; no SRAM access.
- ISSUE:
  - waitrequest=1; drive latched address.
  - Write: mem_we=1, mem_be=latched be. If be==0, suppress mem_we.
  - Read: mem_re=1.
  - Next state is DONE unconditionally; a write commits at this edge even if the request dropped.
- DONE:
  - waitrequest=0 (completing cycle).
  - Read: readdata=mem_rdata combinationally, and the hold reg loads mem_rdata.
  - Next state is IDLE.
- Outside DONE, readdata = hold reg.
- Latency: request held WAIT_STATES+3 cycles; waitrequest low exactly 1 cycle per transfer.
- Back-to-back: a request still high in the cycle after DONE starts a new transfer from IDLE. No pipelining, no outstanding transfers.
- address[1:0] ignored (alignment is the master's job); byte lanes come only from byteenable.
- read&write in the same cycle: perform a write and set proto_err. Only reset clears proto_err.
- mem_re/mem_we are high only in ISSUE; never both high.
- Reset mid-transfer: strobes drop immediately; no partial write committed after the reset edge.

Optional Feature:
MIPS_BUS_MEM_CTRL_STATS_EN: adds outputs stat_reads[31:0], stat_writes[31:0] and stat_stalls[31:0].
- Increment on completed reads (DONE), completed writes (DONE) and cycles with waitrequest=1, respectively.
- All cleared by reset; wrap modulo 2^32.
- Without the macro: ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, be=4'b1111, then read 0x10 -> waitrequest high 2 cycles then low 1; mem_we in cycle 2; readdata=0xDEADBEEF in read completing cycle.
- WAIT_STATES=3: read 0x20 -> waitrequest high exactly 5 cycles; mem_re single-cycle pulse in cycle 5.
- Byte write: preload 0x11223344 at 0x30, write 0xAABBCCDD with be=4'b0010 -> subsequent read returns 0x1122CC44; be=4'b0000 write -> mem_we never asserted, waitrequest still completes.
- Abort: WAIT_STATES=4, drop read in 2nd WAIT cycle -> FSM IDLE next cycle, no mem_re pulse, readdata unchanged.
- read&write both high with data 0x5 -> write performed, proto_err=1 and remains 1 until reset; async reset asserted during ISSUE -> mem_we falls without a clock edge, proto_err=0.
- With MIPS_BUS_MEM_CTRL_STATS_EN, WAIT_STATES=1: 2 reads + 1 write -> stat_reads=2, stat_writes=1, stat_stalls=9.
